// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and parity helper.
// Shared with the receive side so both ends agree on framing.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Word is zero-extended to 9 bits; the padding does not change the XOR.
    function automatic logic parity_of(input logic [8:0] word, input int mode);
        logic even_bit;
        even_bit = ^word;
        return (mode == PARITY_ODD) ? ~even_bit : even_bit;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmit serializer: accepts a word on valid/ready and shifts it out
// LSB-first, one bit per rising edge of the baud generator's bclk.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bclk,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 valid,
    output logic                 ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $fatal(1, "uart_tx: DATA_BITS=%0d must be 5..9", DATA_BITS);
    end
    if (PARITY != PARITY_NONE && PARITY != PARITY_ODD && PARITY != PARITY_EVEN) begin : g_bad_parity
        $fatal(1, "uart_tx: PARITY=%0d must be 0, 1 or 2", PARITY);
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $fatal(1, "uart_tx: STOP_BITS=%0d must be 1 or 2", STOP_BITS);
    end

    localparam int                 IDX_W     = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(DATA_BITS - 1);
    localparam logic               LAST_STOP = 1'(STOP_BITS - 1);

    state_t               state_reg,  state_next;
    logic                 bclk_q;
    logic [DATA_BITS-1:0] shift_reg,  shift_next;
    logic                 parity_reg, parity_next;
    logic [IDX_W-1:0]     idx_reg,    idx_next;
    logic                 stop_reg,   stop_next;
    logic                 tx_reg,     tx_next;
    logic                 done_reg,   done_next;
    logic                 tick;

    assign tick  = bclk & ~bclk_q;
    assign ready = (state_reg == ST_IDLE);
    assign busy  = (state_reg != ST_IDLE);
    assign tx    = tx_reg;
    assign done  = done_reg;

    always_comb begin
        state_next  = state_reg;
        shift_next  = shift_reg;
        parity_next = parity_reg;
        idx_next    = idx_reg;
        stop_next   = stop_reg;
        tx_next     = tx_reg;
        done_next   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // Ticks are deliberately ignored here; only the handshake moves us on.
                if (valid) begin
                    shift_next  = data;
                    parity_next = parity_of(9'(data), PARITY);
                    state_next  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (tick) begin
                    tx_next    = 1'b0;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    tx_next    = shift_reg[0];
                    shift_next = shift_reg >> 1;
                    idx_next   = '0;
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (idx_reg == LAST_IDX) begin
                        if (PARITY != PARITY_NONE) begin
                            tx_next    = parity_reg;
                            state_next = ST_PARITY;
                        end else begin
                            tx_next    = 1'b1;
                            stop_next  = 1'b0;
                            state_next = ST_STOP;
                        end
                    end else begin
                        tx_next    = shift_reg[0];
                        shift_next = shift_reg >> 1;
                        idx_next   = idx_reg + IDX_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    tx_next    = 1'b1;
                    stop_next  = 1'b0;
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (stop_reg == LAST_STOP) begin
                        done_next  = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        stop_next = stop_reg + 1'b1;
                    end
                end
            end
            default: begin
                tx_next    = 1'b1;
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            bclk_q     <= 1'b0;
            shift_reg  <= '0;
            parity_reg <= 1'b0;
            idx_reg    <= '0;
            stop_reg   <= 1'b0;
            tx_reg     <= 1'b1;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            bclk_q     <= bclk;
            shift_reg  <= shift_next;
            parity_reg <= parity_next;
            idx_reg    <= idx_next;
            stop_reg   <= stop_next;
            tx_reg     <= tx_next;
            done_reg   <= done_next;
        end
    end

    idx_in_range: assert property (@(posedge clk) disable iff (reset) idx_reg <= LAST_IDX)
        else $fatal(1, "uart_tx: bit index %0d exceeds %0d", idx_reg, LAST_IDX);

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four configurations (8N1, 8E1, 8O1, 8N2) driven from a
// shared bit clock with 16 clk per bit; frames are compared bit by bit.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       bclk = 1'b0;
    logic       bclk_d = 1'b0;
    logic [3:0] bcnt = 4'd0;
    logic       tick_tb;

    logic [7:0] data_r [4];
    logic       valid_r [4];
    logic [3:0] ready_w, tx_w, busy_w, done_w;

    int checks = 0;
    int errors = 0;
    int done_cnt [4];
    int exp_done [4];
    int par_of   [4] = '{0, 2, 1, 0};
    int stops_of [4] = '{1, 1, 1, 2};

    always #5 clk = ~clk;

    // Behavioural baud generator: bclk period is 16 clk, high for 8.
    always @(posedge clk) begin
        bcnt   <= bcnt + 4'd1;
        bclk   <= (bcnt < 4'd8);
        bclk_d <= bclk;
    end
    assign tick_tb = bclk & ~bclk_d;

    uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .reset(reset), .bclk(bclk), .data(data_r[0]), .valid(valid_r[0]),
        .ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));
    uart_tx #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .reset(reset), .bclk(bclk), .data(data_r[1]), .valid(valid_r[1]),
        .ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));
    uart_tx #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .reset(reset), .bclk(bclk), .data(data_r[2]), .valid(valid_r[2]),
        .ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));
    uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
        .clk(clk), .reset(reset), .bclk(bclk), .data(data_r[3]), .valid(valid_r[3]),
        .ready(ready_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .done(done_w[3]));

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) if (done_w[k] === 1'b1) done_cnt[k]++;
    end

    typedef struct {
        int         inst;
        logic [7:0] word;
        logic [11:0] bits;
        int         len;
    } vec_t;

    // Reference frame from the framing rules: start, LSB-first data, parity, stops.
    function automatic logic [11:0] frame_bits(input logic [7:0] w, input int par,
                                               input int stops, output int len);
        logic [11:0] f;
        int n;
        logic p;
        f = '0;
        n = 1;
        for (int i = 0; i < 8; i++) begin
            f[n] = w[i];
            n++;
        end
        if (par != 0) begin
            p = ($countones(w) % 2) == 1;
            if (par == 1) p = ~p;
            f[n] = p;
            n++;
        end
        for (int s = 0; s < stops; s++) begin
            f[n] = 1'b1;
            n++;
        end
        len = n;
        return f;
    endfunction

    // Called at a negedge; returns at the negedge just after the next tick edge.
    task automatic wait_tick(input int k, input logic hold, output bit ok);
        bit bad;
        bad = 0;
        ok  = 0;
        for (int n = 0; n < 40; n++) begin
            if (tx_w[k] !== hold || ready_w[k] !== 1'b0 || busy_w[k] !== 1'b1 || done_w[k] !== 1'b0)
                bad = 1;
            if (tick_tb) begin
                ok = 1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL hold inst%0d: tx=%b ready=%b busy=%b done=%b, required tx=%b ready=0 busy=1 done=0 between ticks",
                     k, tx_w[k], ready_w[k], busy_w[k], done_w[k], hold);
        end
        if (!ok) begin
            errors++;
            $display("FAIL tick_timeout inst%0d: no bit boundary within 40 clk, required one every 16", k);
        end
    endtask

    task automatic accept(input int k, input logic [7:0] w);
        data_r[k]  = w;
        valid_r[k] = 1'b1;
        checks++;
        if (ready_w[k] !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready inst%0d: ready=%b, required 1", k, ready_w[k]);
        end
        @(negedge clk);
        checks++;
        if (busy_w[k] !== 1'b1 || ready_w[k] !== 1'b0) begin
            errors++;
            $display("FAIL accept_busy inst%0d: busy=%b ready=%b, required busy=1 ready=0",
                     k, busy_w[k], ready_w[k]);
        end
    endtask

    task automatic expect_frame(input int k, input logic [11:0] bits, input int len);
        bit ok;
        logic hold;
        hold = 1'b1;
        for (int i = 0; i < len; i++) begin
            wait_tick(k, hold, ok);
            if (!ok) return;
            checks++;
            if (tx_w[k] !== bits[i]) begin
                errors++;
                $display("FAIL frame_bit inst%0d bit%0d: tx=%b, required %b", k, i, tx_w[k], bits[i]);
            end
            hold = bits[i];
        end
        wait_tick(k, hold, ok);
        if (!ok) return;
        checks++;
        exp_done[k]++;
        if (done_w[k] !== 1'b1 || ready_w[k] !== 1'b1 || busy_w[k] !== 1'b0 || tx_w[k] !== 1'b1) begin
            errors++;
            $display("FAIL frame_end inst%0d: done=%b ready=%b busy=%b tx=%b, required 1 1 0 1",
                     k, done_w[k], ready_w[k], busy_w[k], tx_w[k]);
        end
        $display("frame inst%0d len=%0d bits=%b", k, len, bits);
    endtask

    vec_t vecs [6];

    initial begin
        bit ok;
        int len;
        logic [11:0] fb;

        vecs[0] = '{0, 8'hA5, {2'b00, 1'b1, 8'hA5, 1'b0}, 10};
        vecs[1] = '{1, 8'hA5, {1'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11};
        vecs[2] = '{2, 8'hA5, {1'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11};
        vecs[3] = '{2, 8'h01, {1'b0, 1'b1, 1'b0, 8'h01, 1'b0}, 11};
        vecs[4] = '{1, 8'h01, {1'b0, 1'b1, 1'b1, 8'h01, 1'b0}, 11};
        vecs[5] = '{3, 8'h3C, {1'b0, 2'b11, 8'h3C, 1'b0}, 11};

        for (int k = 0; k < 4; k++) begin
            data_r[k] = 8'h00;
            valid_r[k] = 1'b0;
            done_cnt[k] = 0;
            exp_done[k] = 0;
        end

        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({tx_w[k], ready_w[k], busy_w[k], done_w[k]} !== 4'b1100) begin
                errors++;
                $display("FAIL reset_state inst%0d: tx/ready/busy/done=%b, required 1100",
                         k, {tx_w[k], ready_w[k], busy_w[k], done_w[k]});
            end
        end
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Directed vectors
        for (int v = 0; v < 6; v++) begin
            accept(vecs[v].inst, vecs[v].word);
            valid_r[vecs[v].inst] = 1'b0;
            expect_frame(vecs[v].inst, vecs[v].bits, vecs[v].len);
            repeat (3) @(negedge clk);
        end

        // Two stop bits, back-to-back with valid held high
        accept(3, 8'h00);
        data_r[3] = 8'hFF;
        expect_frame(3, {1'b0, 2'b11, 8'h00, 1'b0}, 11);
        accept(3, 8'hFF);
        valid_r[3] = 1'b0;
        expect_frame(3, {1'b0, 2'b11, 8'hFF, 1'b0}, 11);
        repeat (4) @(negedge clk);

        // Handshake hold-off: data and valid churn while busy
        accept(0, 8'h3C);
        valid_r[0] = 1'b0;
        fork
            expect_frame(0, {2'b00, 1'b1, 8'h3C, 1'b0}, 10);
            begin
                repeat (60) begin
                    @(negedge clk);
                    valid_r[0] = ~valid_r[0];
                    data_r[0]  = 8'hFF;
                end
                valid_r[0] = 1'b0;
            end
        join
        repeat (4) @(negedge clk);

        // Reset during data bit 3 of 0xF7 (bit3 is 0)
        accept(0, 8'hF7);
        valid_r[0] = 1'b0;
        wait_tick(0, 1'b1, ok);
        wait_tick(0, 1'b0, ok);
        wait_tick(0, 1'b1, ok);
        wait_tick(0, 1'b1, ok);
        wait_tick(0, 1'b1, ok);
        checks++;
        if (tx_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL bit3_before_reset: tx=%b, required 0", tx_w[0]);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({tx_w[0], ready_w[0], busy_w[0], done_w[0]} !== 4'b1100) begin
            errors++;
            $display("FAIL async_reset: tx/ready/busy/done=%b, required 1100",
                     {tx_w[0], ready_w[0], busy_w[0], done_w[0]});
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        checks++;
        if (done_cnt[0] !== exp_done[0]) begin
            errors++;
            $display("FAIL reset_no_done: done pulses=%0d, required %0d", done_cnt[0], exp_done[0]);
        end
        accept(0, 8'h55);
        valid_r[0] = 1'b0;
        expect_frame(0, {2'b00, 1'b1, 8'h55, 1'b0}, 10);

        // Randomized frames against the reference model
        for (int r = 0; r < 24; r++) begin
            int k;
            logic [7:0] w;
            k = $urandom_range(0, 3);
            w = 8'($urandom);
            repeat ($urandom_range(0, 30)) @(negedge clk);
            fb = frame_bits(w, par_of[k], stops_of[k], len);
            accept(k, w);
            valid_r[k] = 1'b0;
            data_r[k]  = 8'($urandom);
            expect_frame(k, fb, len);
        end

        repeat (40) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (done_cnt[k] !== exp_done[k]) begin
                errors++;
                $display("FAIL done_count inst%0d: pulses=%0d, required %0d", k, done_cnt[k], exp_done[k]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
